// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and defaults for the PUF challenge sequencer.
// Holds the FSM state encoding, the response word layout and the per-state output decode.
package puf_pkg;
  localparam int RSP_WIDTH          = 16;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_ARM_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;

  typedef enum logic [2:0] {IDLE, ARM, RUN, CAPTURE, NEXT} seq_state_t;

  typedef struct packed {
    logic [7:0] challenge;
    logic [7:0] response;
  } rsp_word_t;

  typedef struct packed {
    logic busy;
    logic puf_reset;
    logic puf_en;
  } seq_ctl_t;

  // Output values for a state; loaded together with the state so the outputs are registered.
  function automatic seq_ctl_t ctl_of(seq_state_t s);
    seq_ctl_t c;
    c.busy      = (s != IDLE);
    c.puf_reset = (s == IDLE) || (s == ARM);
    c.puf_en    = (s == RUN);
    return c;
  endfunction
endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// PUF-side bus and response stream of the challenge sequencer.
interface puf_challenge_sequencer_if;
  import puf_pkg::*;
  logic [7:0]           puf_challenge;
  logic [31:0]          puf_enable;
  logic                 puf_reset;
  logic [7:0]           puf_response;
  logic                 puf_done;
  logic [RSP_WIDTH-1:0] rsp_data;
  logic                 rsp_valid;
  logic                 rsp_ready;

  modport master (
    output puf_challenge, puf_enable, puf_reset, rsp_data, rsp_valid,
    input  puf_response, puf_done, rsp_ready
  );
  modport slave (
    input  puf_challenge, puf_enable, puf_reset, rsp_data, rsp_valid,
    output puf_response, puf_done, rsp_ready
  );
endinterface

// File: rtl/puf_challenge_sequencer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even if the head is popped in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Steps a PUF through seed, seed+1, ... challenges and queues {challenge, response} words.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int ARM_CYCLES     = DEF_ARM_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  seed,
  input  logic [7:0]                  num_challenges,
  puf_challenge_sequencer_if.master   bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        seq_done,
  output logic                        timeout_err
);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t      state;
  seq_ctl_t        ctl;
  logic [7:0]      seed_q, num_q, idx_q, resp_q;
  logic [AW-1:0]   arm_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            fifo_full, fifo_empty, push, pop;
  rsp_word_t       push_word, head_word;

  assign bus.puf_challenge = seed_q + idx_q;
  assign bus.puf_reset     = ctl.puf_reset;
  assign bus.puf_enable    = {32{ctl.puf_en}};
  assign busy              = ctl.busy;
  assign push              = (state == CAPTURE) && !fifo_full;
  assign pop               = bus.rsp_valid && bus.rsp_ready;
  assign push_word         = {bus.puf_challenge, resp_q};
  assign bus.rsp_valid     = !fifo_empty;
  assign bus.rsp_data      = head_word;

  sync_fifo #(.WIDTH(RSP_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ctl         <= ctl_of(IDLE);
      seed_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      resp_q      <= '0;
      arm_cnt     <= '0;
      tmo_cnt     <= '0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          timeout_err <= 1'b0;
          if (num_challenges != 8'd0) begin
            seed_q  <= seed;
            num_q   <= num_challenges;
            idx_q   <= '0;
            arm_cnt <= '0;
            state   <= ARM;
            ctl     <= ctl_of(ARM);
          end else begin
            seq_done <= 1'b1;
          end
        end
        ARM: if (arm_cnt == AW'(ARM_CYCLES - 1)) begin
          tmo_cnt <= '0;
          state   <= RUN;
          ctl     <= ctl_of(RUN);
        end else begin
          arm_cnt <= arm_cnt + AW'(1);
        end
        RUN: if (bus.puf_done) begin
          resp_q <= bus.puf_response;
          state  <= CAPTURE;
          ctl    <= ctl_of(CAPTURE);
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the whole sequence; nothing is queued for this challenge.
          timeout_err <= 1'b1;
          seq_done    <= 1'b1;
          state       <= IDLE;
          ctl         <= ctl_of(IDLE);
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
        CAPTURE: if (!fifo_full) begin
          state <= NEXT;
          ctl   <= ctl_of(NEXT);
        end
        NEXT: begin
          idx_q <= idx_q + 8'd1;
          if (8'(idx_q + 8'd1) == num_q) begin
            seq_done <= 1'b1;
            state    <= IDLE;
            ctl      <= ctl_of(IDLE);
          end else begin
            arm_cnt <= '0;
            state   <= ARM;
            ctl     <= ctl_of(ARM);
          end
        end
        default: begin
          state <= IDLE;
          ctl   <= ctl_of(IDLE);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: random PUF responses, expected words derived as {seed+k, table[seed+k]}.
module tb_puf_challenge_sequencer;
  localparam int DEPTH = 16;
  localparam int ARMC  = 4;
  localparam int TMO   = 100;

  logic       clock, reset, start;
  logic [7:0] seed, num;
  logic [4:0] fifo_count;
  logic       busy, seq_done, timeout_err;

  puf_challenge_sequencer_if bus();

  puf_challenge_sequencer #(.FIFO_DEPTH(DEPTH), .ARM_CYCLES(ARMC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed), .num_challenges(num),
    .bus(bus), .fifo_count(fifo_count), .busy(busy), .seq_done(seq_done),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] resp_tab [256];

  // PUF model: answers puf_delay cycles after puf_reset is released.
  int puf_delay = 50, puf_cnt = 0;
  bit puf_respond = 1;
  initial begin
    bus.puf_done = 1'b0; bus.puf_response = 8'h00;
    forever begin
      @(negedge clock);
      if (bus.puf_reset !== 1'b0) begin
        puf_cnt = 0; bus.puf_done = 1'b0;
      end else begin
        puf_cnt++;
        if (puf_respond && puf_cnt == puf_delay) begin
          bus.puf_done = 1'b1; bus.puf_response = resp_tab[bus.puf_challenge];
        end else bus.puf_done = 1'b0;
      end
    end
  end

  // Monitor, sampled mid-cycle: popped words, pulses, ARM/RUN lengths, hold stability.
  logic [15:0] got_q [$];
  logic [7:0]  run_ch_q [$];
  int arm_len_q [$], run_len_q [$];
  int done_pulses = 0, hold_bad = 0, max_count = 0, run_rst_bad = 0;
  initial begin
    int arm_run, run_run;
    bit prev_hold;
    logic [15:0] prev_data;
    arm_run = 0; run_run = 0; prev_hold = 0; prev_data = '0;
    forever begin
      @(negedge clock); #1;
      if (reset) begin
        arm_run = 0; run_run = 0; prev_hold = 0;
      end else begin
        if (prev_hold && (!bus.rsp_valid || bus.rsp_data !== prev_data)) hold_bad++;
        prev_hold = bus.rsp_valid && !bus.rsp_ready;
        prev_data = bus.rsp_data;
        if (bus.rsp_valid && bus.rsp_ready) got_q.push_back(bus.rsp_data);
        if (seq_done) done_pulses++;
        if (busy && bus.puf_reset) arm_run++;
        else if (arm_run != 0) begin arm_len_q.push_back(arm_run); arm_run = 0; end
        if (bus.puf_enable == '1) begin
          if (run_run == 0) run_ch_q.push_back(bus.puf_challenge);
          if (bus.puf_reset !== 1'b0) run_rst_bad++;
          run_run++;
        end else if (run_run != 0) begin run_len_q.push_back(run_run); run_run = 0; end
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      end
    end
  end

  function automatic logic [15:0] exp_word(input logic [7:0] s, input int k);
    logic [7:0] ch;
    ch = s + 8'(k);
    return {ch, resp_tab[ch]};
  endfunction

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] n);
    @(negedge clock); start = 1'b1; seed = s; num = n;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy, output bit ok);
    int d0;
    d0 = done_pulses; ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
      #2;
      if (done_pulses != d0) begin ok = 1; break; end
    end
  endtask

  task automatic drain();
    @(negedge clock); bus.rsp_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock); #2;
      if (!bus.rsp_valid) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    n_cmp++; if (bus.puf_enable !== 32'h0) begin n_bad++; $display("FAIL rst_enable: got %h want 0", bus.puf_enable); end
    n_cmp++; if (bus.puf_reset !== 1'b1) begin n_bad++; $display("FAIL rst_puf_reset: got %b want 1", bus.puf_reset); end
    n_cmp++; if (bus.puf_challenge !== 8'h00) begin n_bad++; $display("FAIL rst_challenge: got %h want 00", bus.puf_challenge); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", bus.rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_cmp++; if ({seq_done, timeout_err} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {seq_done, timeout_err}); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #2;
    n_cmp++; if ({busy, bus.puf_reset} !== 2'b01) begin n_bad++; $display("FAIL rst_idle: got %b want 01", {busy, bus.puf_reset}); end
  endtask

  task automatic test_basic();
    bit ok; int d0;
    got_q.delete(); run_ch_q.delete(); arm_len_q.delete(); run_len_q.delete();
    puf_delay = 50; puf_respond = 1;
    @(negedge clock); bus.rsp_ready = 1'b1;
    d0 = done_pulses;
    pulse_start(8'h10, 8'd3);
    wait_done(400, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done: got none want seq_done"); end
    drain(); repeat (3) @(negedge clock); #2;
    n_cmp++; if (done_pulses - d0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", done_pulses - d0); end
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_word(8'h10, k)) begin n_bad++; $display("FAIL basic_word[%0d]: got %h want %h", k, got_q[k], exp_word(8'h10, k)); end
    end
    n_cmp++; if (arm_len_q.size() !== 3 || run_len_q.size() !== 3) begin n_bad++; $display("FAIL basic_phases: got %0d/%0d want 3/3", arm_len_q.size(), run_len_q.size()); end
    for (int k = 0; k < arm_len_q.size(); k++) begin
      n_cmp++; if (arm_len_q[k] !== ARMC) begin n_bad++; $display("FAIL basic_arm_len[%0d]: got %0d want %0d", k, arm_len_q[k], ARMC); end
    end
    for (int k = 0; k < run_len_q.size(); k++) begin
      n_cmp++; if (run_len_q[k] !== 50) begin n_bad++; $display("FAIL basic_run_len[%0d]: got %0d want 50", k, run_len_q[k]); end
    end
    n_cmp++; if (run_rst_bad !== 0) begin n_bad++; $display("FAIL basic_run_puf_reset: got %0d want 0", run_rst_bad); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] want;
    got_q.delete(); run_ch_q.delete();
    puf_delay = $urandom_range(1, 20);
    pulse_start(8'hFE, 8'd4);
    wait_done(300, 0, ok);
    drain();
    n_cmp++; if (!ok || got_q.size() !== 4) begin n_bad++; $display("FAIL wrap_count: got %0d (done %b) want 4", got_q.size(), ok); end
    for (int k = 0; k < 4 && k < run_ch_q.size(); k++) begin
      want = 8'hFE + 8'(k);
      n_cmp++; if (run_ch_q[k] !== want) begin n_bad++; $display("FAIL wrap_challenge[%0d]: got %h want %h", k, run_ch_q[k], want); end
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_word(8'hFE, k)) begin n_bad++; $display("FAIL wrap_word[%0d]: got %h want %h", k, got_q[k], exp_word(8'hFE, k)); end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] s;
    int n;
    for (int it = 0; it < 4; it++) begin
      got_q.delete();
      s = 8'($urandom); n = $urandom_range(1, 10); puf_delay = $urandom_range(1, 30);
      pulse_start(s, 8'(n));
      wait_done(800, 1, ok);
      drain();
      n_cmp++; if (!ok || got_q.size() !== n) begin n_bad++; $display("FAIL rand%0d_count: got %0d (done %b) want %0d", it, got_q.size(), ok, n); end
      for (int k = 0; k < n && k < got_q.size(); k++) begin
        n_cmp++; if (got_q[k] !== exp_word(s, k)) begin n_bad++; $display("FAIL rand%0d_word[%0d]: got %h want %h", it, k, got_q[k], exp_word(s, k)); end
      end
    end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL rand_hold: got %0d unstable cycles want 0", hold_bad); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] s;
    got_q.delete(); max_count = 0; puf_delay = 3;
    @(negedge clock); bus.rsp_ready = 1'b0;
    s = 8'($urandom);
    pulse_start(s, 8'd20);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock); #2;
      if (fifo_count == 5'd16) break;
    end
    repeat (40) @(negedge clock);
    #2;
    n_cmp++; if (fifo_count !== 5'd16) begin n_bad++; $display("FAIL bp_full: got %0d want 16", fifo_count); end
    n_cmp++; if ({busy, bus.puf_reset, bus.puf_enable != 0} !== 3'b100) begin n_bad++; $display("FAIL bp_stall: got %b want 100", {busy, bus.puf_reset, bus.puf_enable != 0}); end
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_word(s, 0)) begin n_bad++; $display("FAIL bp_head: got %b/%h want 1/%h", bus.rsp_valid, bus.rsp_data, exp_word(s, 0)); end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d want 0", hold_bad); end
    @(negedge clock); bus.rsp_ready = 1'b1;
    wait_done(800, 0, ok);
    drain();
    n_cmp++; if (!ok || got_q.size() !== 20) begin n_bad++; $display("FAIL bp_count: got %0d (done %b) want 20", got_q.size(), ok); end
    for (int k = 0; k < 20 && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_word(s, k)) begin n_bad++; $display("FAIL bp_word[%0d]: got %h want %h", k, got_q[k], exp_word(s, k)); end
    end
    n_cmp++; if (max_count !== DEPTH) begin n_bad++; $display("FAIL bp_max_count: got %0d want %0d", max_count, DEPTH); end
  endtask

  task automatic test_timeout();
    bit ok; int d0;
    got_q.delete(); run_len_q.delete();
    puf_respond = 0; d0 = done_pulses;
    pulse_start(8'($urandom), 8'd3);
    wait_done(300, 0, ok);
    n_cmp++; if (!ok || timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b (done %b) want 1", timeout_err, ok); end
    n_cmp++; if ({busy, fifo_count} !== 6'd0) begin n_bad++; $display("FAIL tmo_idle: got busy %b count %0d want 0/0", busy, fifo_count); end
    repeat (5) @(negedge clock);
    #2;
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    n_cmp++; if (done_pulses - d0 !== 1 || got_q.size() !== 0) begin n_bad++; $display("FAIL tmo_pulse_push: got %0d/%0d want 1/0", done_pulses - d0, got_q.size()); end
    n_cmp++; if (run_len_q.size() !== 1 || run_len_q[0] !== TMO) begin n_bad++; $display("FAIL tmo_run_len: got %0d entries first %0d want 1/%0d", run_len_q.size(), (run_len_q.size() > 0) ? run_len_q[0] : -1, TMO); end
    puf_respond = 1;
  endtask

  task automatic test_zero_and_busy();
    bit ok; int d0, na;
    logic [7:0] s;
    d0 = done_pulses; na = arm_len_q.size();
    pulse_start(8'h33, 8'd0);
    #2;
    n_cmp++; if ({seq_done, busy, timeout_err} !== 3'b100) begin n_bad++; $display("FAIL zero_pulse: got %b want 100", {seq_done, busy, timeout_err}); end
    @(negedge clock); #2;
    n_cmp++; if ({seq_done, busy} !== 2'b00 || done_pulses - d0 !== 1 || arm_len_q.size() !== na) begin n_bad++; $display("FAIL zero_after: got %b pulses %0d arms %0d want 00/1/%0d", {seq_done, busy}, done_pulses - d0, arm_len_q.size(), na); end
    got_q.delete(); puf_delay = 10;
    s = 8'($urandom);
    pulse_start(s, 8'd2);
    repeat (6) @(negedge clock);
    pulse_start(s ^ 8'h80, 8'd5);
    wait_done(300, 0, ok);
    drain();
    repeat (10) @(negedge clock);
    #2;
    n_cmp++; if (!ok || busy !== 1'b0 || got_q.size() !== 2) begin n_bad++; $display("FAIL busy_ignore: got busy %b words %0d (done %b) want 0/2", busy, got_q.size(), ok); end
    for (int k = 0; k < 2 && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_word(s, k)) begin n_bad++; $display("FAIL busy_word[%0d]: got %h want %h", k, got_q[k], exp_word(s, k)); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); run_ch_q.delete(); puf_delay = 30;
    @(negedge clock); bus.rsp_ready = 1'b0;
    pulse_start(8'($urandom), 8'd3);
    for (int c = 0; c < 300; c++) begin
      @(negedge clock); #2;
      if (run_ch_q.size() == 2) break;
    end
    repeat (4) @(negedge clock);
    #2;
    n_cmp++; if (fifo_count !== 5'd1 || bus.puf_enable !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_pre: got count %0d en %h want 1/ffffffff", fifo_count, bus.puf_enable); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #2;
    n_cmp++; if (bus.puf_enable !== 32'h0 || bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_en_valid: got %h/%b want 0/0", bus.puf_enable, bus.rsp_valid); end
    n_cmp++; if (fifo_count !== 5'd0 || busy !== 1'b0 || bus.puf_reset !== 1'b1) begin n_bad++; $display("FAIL mid_state: got count %0d busy %b rst %b want 0/0/1", fifo_count, busy, bus.puf_reset); end
    @(negedge clock); reset = 1'b0; bus.rsp_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed = '0; num = '0; bus.rsp_ready = 1'b0;
    for (int k = 0; k < 256; k++) resp_tab[k] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_backpressure();
    test_timeout();
    test_zero_and_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: response FIFO entries, power of two.
REQ-002 SHALL have parameter ARM_CYCLES, default 4: cycles puf_reset is held before each challenge.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: maximum RUN cycles before abort.
REQ-004 SHALL have port clock, in, 1, sole clock.
REQ-005 SHALL have port reset, in, 1: reset is synchronous and active-high.
REQ-006 SHALL have port start, in, 1: begin a sequence; sampled in IDLE only.
REQ-007 SHALL have port seed, in, 8: first challenge value.
REQ-008 SHALL have port num_challenges, in, 8: challenges per sequence; 0 = none.
REQ-009 SHALL have port puf_challenge, out, 8: challenge driven to the PUF.
REQ-010 SHALL have port puf_enable, out, 32: ring-oscillator enables.
REQ-011 SHALL have port puf_reset, out, 1: PUF reset / host acknowledge.
REQ-012 SHALL have port puf_response, in, 8: PUF response byte.
REQ-013 SHALL have port puf_done, in, 1: PUF response ready.
REQ-014 SHALL have port rsp_data, out, 16: {challenge[7:0], response[7:0]} at the FIFO head.
REQ-015 SHALL have port rsp_valid, out, 1: FIFO non-empty.
REQ-016 SHALL have port rsp_ready, in, 1: consumer accepts the head word.
REQ-017 SHALL have port fifo_count, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-018 SHALL have port busy, out, 1: high in any state other than IDLE.
REQ-019 SHALL have port seq_done, out, 1: one-cycle pulse at the end of a sequence.
REQ-020 SHALL have port timeout_err, out, 1: sticky error flag.

Function
REQ-021 SHALL implement FSM states IDLE, ARM, RUN, CAPTURE, NEXT.
REQ-022 SHALL, in IDLE, go to ARM on start with num_challenges!=0, latch seed and num_challenges, and clear index i.
REQ-023 SHALL, in IDLE, on start with num_challenges==0, stay in IDLE and pulse seq_done in the following cycle.
REQ-024 SHALL assert puf_reset=1 in IDLE and ARM, and puf_reset=0 elsewhere.
REQ-025 SHALL hold ARM for exactly ARM_CYCLES cycles, then enter RUN.
REQ-026 SHALL drive puf_challenge = (seed_latched + i) mod 256 in every state; the value is stable from ARM through CAPTURE.
REQ-027 SHALL drive puf_enable = 32'hFFFF_FFFF in RUN only, and 0 in all other states.
REQ-028 SHALL, in RUN, latch puf_response and enter CAPTURE in the cycle puf_done==1 is sampled.
REQ-029 SHALL run the RUN timeout counter from 0; on reaching TIMEOUT_CYCLES-1 without puf_done it SHALL set timeout_err, push nothing, pulse seq_done and return to IDLE.
REQ-030 SHALL, in CAPTURE, push {puf_challenge, latched response} when the FIFO is not full, then go to NEXT; if full, it SHALL stall in CAPTURE.
REQ-031 SHALL treat full as blocking a push even when a pop occurs in the same cycle; the push then succeeds the next cycle.
REQ-032 SHALL, in NEXT, increment i; if i+1==num_latched it SHALL pulse seq_done and go to IDLE, otherwise go to ARM.
REQ-033 SHALL ignore start while busy.
REQ-034 SHALL make the FIFO first-word-fall-through: rsp_data is valid in the same cycle as rsp_valid and held stable while rsp_valid && !rsp_ready.
REQ-035 SHALL pop on rsp_valid && rsp_ready; it SHALL accept simultaneous push and pop when not full, leaving the count unchanged.
REQ-036 SHALL wrap FIFO pointers modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-037 SHALL clear timeout_err only by reset or by start accepted in IDLE.

Reset
REQ-038 SHALL, on reset, place the FSM in IDLE and clear FIFO pointers and count, timeout counter, i, seq_done and timeout_err.
REQ-039 SHALL give outputs these reset values: puf_enable=0, puf_reset=1, puf_challenge=0, rsp_valid=0, rsp_data=0, busy=0.
REQ-040 SHALL, on reset mid-sequence, abort immediately, discard FIFO contents and drop puf_enable the cycle after reset is sampled.

Structure
REQ-041 SHALL define in shared package puf_pkg: the state enum, the RSP_WIDTH=16 constant and default parameter values.
REQ-042 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports clock, reset, push, pop, din, dout, full, empty, count).

Verification
REQ-043 SHALL cover: seed=8'h10, num=3, PUF model done 50 cycles after puf_reset falls, rsp_ready=1 -> words 16'h10xx, 16'h11xx, 16'h12xx in order, one seq_done pulse.
REQ-044 SHALL cover: seed=8'hFE, num=4 -> challenges FE, FF, 00, 01 (wrap).
REQ-045 SHALL cover: rsp_ready=0, num=20, FIFO_DEPTH=16 -> fifo_count stops at 16, FSM stalls in CAPTURE, then rsp_ready=1 -> all 20 words delivered with no loss or duplicates.
REQ-046 SHALL cover: puf_done never asserted, TIMEOUT_CYCLES=100 -> timeout_err=1 after 100 RUN cycles, no push, seq_done pulse, IDLE.
REQ-047 SHALL cover: reset asserted in RUN of the 2nd challenge -> next cycle puf_enable=0, rsp_valid=0, fifo_count=0, busy=0.
REQ-048 SHALL cover: start with num=0 -> no ARM entry, seq_done pulse one cycle later; start pulsed while busy -> ignored.
